// File: rtl/twiddle_seq.sv
// twiddle_seq: streams FFT twiddle factors for k = j*stride mod N.
// The values come from a quarter-wave cosine ROM and go through a two-stage
// pipeline (index register, then lookup/sign register). The consumer applies
// backpressure with tw_ready, and a stall freezes the whole pipeline.
module twiddle_seq #(
  parameter int N    = 24,
  parameter int W    = 18,
  parameter int FRAC = 8,
  localparam int AW  = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [AW-1:0]       stride,
  input  logic [AW:0]         count,
  input  logic                inverse,
  output logic                tw_valid,
  input  logic                tw_ready,
  output logic signed [W-1:0] tw_re,
  output logic signed [W-1:0] tw_im,
  output logic [AW-1:0]       tw_idx,
  output logic                busy,
  output logic                done
);

  localparam int QN = N / 4;
  localparam int QW = $clog2(QN + 1);
  localparam logic [AW:0]   N_EXT = (AW+1)'(N);
  localparam logic [AW-1:0] Q1_K  = AW'(QN);
  localparam logic [AW-1:0] Q2_K  = AW'(2 * QN);
  localparam logic [AW-1:0] Q3_K  = AW'(3 * QN);
  localparam logic [QW-1:0] QN_Q  = QW'(QN);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic                  done_reg, done_next;
  logic [AW-1:0]         stride_reg;
  logic                  inv_reg;
  logic [AW-1:0]         acc_reg, acc_next;
  logic [AW:0]           sum_ext;
  logic [AW:0]           issue_left_reg, hs_left_reg;
  logic                  s1_valid_reg;
  logic [AW-1:0]         s1_k_reg;
  logic                  tw_valid_reg;
  logic signed [W-1:0]   tw_re_reg, tw_im_reg;
  logic [AW-1:0]         tw_idx_reg;
  logic                  accept, zero_start, hs, last_hs, en;
  logic [1:0]            quad;
  logic [AW-1:0]         r_k;
  logic [QW-1:0]         r_q, rr_q, cos_addr, sin_addr;
  logic                  cos_neg, im_neg;
  logic signed [W-1:0]   qtab [0:QN];

  // Evaluate round(2^FRAC * cos(2*pi*r/N)) at elaboration using a Taylor series.
  // The argument never exceeds pi/2, so 16 terms reach full double precision.
  // The result is never negative, so truncating after adding 0.5 rounds correctly.
  function automatic logic signed [W-1:0] qcos(input int r);
    real x, term, sum;
    int  v;
    x    = 2.0 * 3.14159265358979323846 * real'(r) / real'(N);
    term = 1.0;
    sum  = 1.0;
    for (int i = 1; i <= 16; i++) begin
      term = -term * x * x / real'((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    v = $rtoi(sum * real'(1 << FRAC) + 0.5);
    return W'(v);
  endfunction

  // Constant quarter-wave cosine table. Entries 0 and N/4 give the exact quadrant points.
  generate
    for (genvar gi = 0; gi <= QN; gi++) begin : g_qrom
      assign qtab[gi] = qcos(gi);
    end
  endgenerate

  // State register and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    accept     = (state_reg == IDLE) && start && (count != '0);
    zero_start = (state_reg == IDLE) && start && (count == '0);
    hs         = tw_valid_reg && tw_ready;
    en         = !tw_valid_reg || tw_ready;
    last_hs    = (state_reg == RUN) && hs && (hs_left_reg == (AW+1)'(1));
    done_next  = zero_start || last_hs;
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)  state_next = RUN;
      RUN:     if (last_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy     = (state_reg == RUN);
    done     = done_reg;
    tw_valid = tw_valid_reg;
    tw_re    = tw_re_reg;
    tw_im    = tw_im_reg;
    tw_idx   = tw_idx_reg;
  end

  // Angle accumulator: add stride and wrap modulo N with a single subtract
  always_comb begin
    sum_ext  = {1'b0, acc_reg} + {1'b0, stride_reg};
    acc_next = (sum_ext >= N_EXT) ? AW'(sum_ext - N_EXT) : AW'(sum_ext);
  end

  // Quadrant split and folding of the index into the quarter-wave table
  always_comb begin
    quad = 2'd0;
    r_k  = s1_k_reg;
    if (s1_k_reg >= Q3_K) begin
      quad = 2'd3;
      r_k  = s1_k_reg - Q3_K;
    end else if (s1_k_reg >= Q2_K) begin
      quad = 2'd2;
      r_k  = s1_k_reg - Q2_K;
    end else if (s1_k_reg >= Q1_K) begin
      quad = 2'd1;
      r_k  = s1_k_reg - Q1_K;
    end
    r_q      = QW'(r_k);
    rr_q     = QN_Q - r_q;
    cos_addr = quad[0] ? rr_q : r_q;
    sin_addr = quad[0] ? r_q : rr_q;
    cos_neg  = quad[0] ^ quad[1];
    // sin is negative in q2/q3; the forward twiddle uses -sin, so flip unless inverse
    im_neg   = quad[1] ^ ~inv_reg;
  end

  // Capture on start, then the index stage with its issue and handshake counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_reg     <= '0;
      inv_reg        <= 1'b0;
      acc_reg        <= '0;
      issue_left_reg <= '0;
      hs_left_reg    <= '0;
      s1_valid_reg   <= 1'b0;
      s1_k_reg       <= '0;
    end else if (accept) begin
      stride_reg     <= stride;
      inv_reg        <= inverse;
      acc_reg        <= '0;
      issue_left_reg <= count;
      hs_left_reg    <= count;
    end else begin
      if (hs) hs_left_reg <= hs_left_reg - (AW+1)'(1);
      if (en) begin
        if (issue_left_reg != '0) begin
          s1_valid_reg   <= 1'b1;
          s1_k_reg       <= acc_reg;
          acc_reg        <= acc_next;
          issue_left_reg <= issue_left_reg - (AW+1)'(1);
        end else begin
          s1_valid_reg   <= 1'b0;
        end
      end
    end
  end

  // Lookup/sign stage: registered ROM read that drives the outputs directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_valid_reg <= 1'b0;
      tw_re_reg    <= '0;
      tw_im_reg    <= '0;
      tw_idx_reg   <= '0;
    end else if (en) begin
      tw_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        tw_re_reg  <= cos_neg ? -qtab[cos_addr] : qtab[cos_addr];
        tw_im_reg  <= im_neg  ? -qtab[sin_addr] : qtab[sin_addr];
        tw_idx_reg <= s1_k_reg;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_seq.sv
// Bench for twiddle_seq: a scoreboard queue is filled by stimulus and drained by a monitor.
// The reference model computes twiddles directly from cos/sin.
module tb_twiddle_seq;

  localparam real PI = 3.14159265358979323846;

  typedef struct {
    int idx;
    int re;
    int im;
  } exp_t;

  logic clk, rst_n;

  // small instance: N=24, W=18, FRAC=8
  logic               start, inverse, tw_ready, tw_valid, busy, done;
  logic [4:0]         stride, tw_idx;
  logic [5:0]         count;
  logic signed [17:0] tw_re, tw_im;

  // large instance: N=4096, W=18, FRAC=16
  logic               start_b, inverse_b, tw_ready_b, tw_valid_b, busy_b, done_b;
  logic [11:0]        stride_b, tw_idx_b;
  logic [12:0]        count_b;
  logic signed [17:0] tw_re_b, tw_im_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sq[$];
  exp_t bq[$];
  int   seen_idx[$];
  int   cap_re[24];
  int   cap_im[24];
  int   hs_cnt   = 0;
  int   hs_cnt_b = 0;
  bit   rand_mode = 0;
  bit   prev_stall = 0;
  int   p_re, p_im, p_idx;

  twiddle_seq #(.N(24), .W(18), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stride(stride), .count(count),
    .inverse(inverse), .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_re(tw_re),
    .tw_im(tw_im), .tw_idx(tw_idx), .busy(busy), .done(done)
  );

  twiddle_seq #(.N(4096), .W(18), .FRAC(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stride(stride_b), .count(count_b),
    .inverse(inverse_b), .tw_valid(tw_valid_b), .tw_ready(tw_ready_b), .tw_re(tw_re_b),
    .tw_im(tw_im_b), .tw_idx(tw_idx_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int ref_c(input int k, input int n, input int frac);
    return rnd(real'(1 << frac) * $cos(2.0 * PI * real'(k) / real'(n)));
  endfunction

  function automatic int ref_s(input int k, input int n, input int frac);
    return rnd(real'(1 << frac) * $sin(2.0 * PI * real'(k) / real'(n)));
  endfunction

  // consumer readiness: always ready, or a coin flip per cycle
  initial begin
    tw_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tw_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor for the small instance: stall stability plus in-order scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", tw_valid, 1);
        chk("stall_re", tw_re, p_re);
        chk("stall_im", tw_im, p_im);
        chk("stall_idx", tw_idx, p_idx);
      end
      if (tw_valid && tw_ready) begin
        hs_cnt++;
        seen_idx.push_back(int'(tw_idx));
        if (tw_idx < 24) begin
          cap_re[tw_idx] = tw_re;
          cap_im[tw_idx] = tw_im;
        end
        if (sq.size() == 0) begin
          chk("unexpected_output_qsize", sq.size(), 1);
        end else begin
          e = sq.pop_front();
          chk("tw_idx", tw_idx, e.idx);
          chk("tw_re", tw_re, e.re);
          chk("tw_im", tw_im, e.im);
        end
      end
      prev_stall = tw_valid && !tw_ready;
      p_re  = tw_re;
      p_im  = tw_im;
      p_idx = tw_idx;
    end
  end

  // monitor for the large instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && tw_valid_b && tw_ready_b) begin
      hs_cnt_b++;
      if (bq.size() == 0) begin
        chk("big_unexpected_output_qsize", bq.size(), 1);
      end else begin
        e = bq.pop_front();
        chk("big_tw_idx", tw_idx_b, e.idx);
        chk("big_tw_re", tw_re_b, e.re);
        chk("big_tw_im", tw_im_b, e.im);
      end
    end
  end

  // issue a start, queue the expected sequence and check the pipeline latency
  task automatic start_seq(input int s, input int c, input bit inv);
    exp_t e;
    @(posedge clk);
    #1;
    start   = 1'b1;
    stride  = 5'(s);
    count   = 6'(c);
    inverse = inv;
    hs_cnt  = 0;
    seen_idx.delete();
    for (int j = 0; j < c; j++) begin
      e.idx = (j * s) % 24;
      e.re  = ref_c(e.idx, 24, 8);
      e.im  = inv ? ref_s(e.idx, 24, 8) : -ref_s(e.idx, 24, 8);
      sq.push_back(e);
    end
    @(posedge clk);              // edge t: start accepted
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_after_t", tw_valid, 0);
    @(posedge clk);
    #1;
    chk("valid_after_t1", tw_valid, 0);
    @(posedge clk);
    #1;
    chk("valid_after_t2", tw_valid, 1);
    chk("first_idx", tw_idx, 0);
  endtask

  // wait for done; optionally poke start and change the inputs mid-run
  task automatic wait_done(input int s, input int c, input bit inject);
    bit got;
    got = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(posedge clk);
      #1;
      if (inject && i == 1) begin
        start   = 1'b1;
        stride  = 5'd7;
        count   = 6'd3;
        inverse = ~inverse;
      end
      if (inject && i == 2) start = 1'b0;
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    chk("busy_at_done", busy, 0);
    chk("valid_at_done", tw_valid, 0);
    chk("handshake_count", hs_cnt, c);
    chk("queue_empty", sq.size(), 0);
    $display("seq stride=%0d count=%0d handshakes=%0d inject=%0d", s, c, hs_cnt, inject);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run_seq(input int s, input int c, input bit inv);
    start_seq(s, c, inv);
    wait_done(s, c, 1'b0);
  endtask

  initial begin
    int   exp5[6];
    int   s, c;
    bit   inv, got;
    exp_t e;

    exp5 = '{0, 5, 10, 15, 20, 1};
    rst_n = 1'b1;
    start = 1'b0; stride = '0; count = '0; inverse = 1'b0;
    start_b = 1'b0; stride_b = '0; count_b = '0; inverse_b = 1'b0; tw_ready_b = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", tw_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re", tw_re, 0);
    chk("rst_im", tw_im, 0);
    chk("rst_idx", tw_idx, 0);
    chk("rst_big_valid", tw_valid_b, 0);
    chk("rst_big_busy", busy_b, 0);
    rst_n = 1'b1;

    // full forward sweep and the known values
    run_seq(1, 24, 1'b0);
    chk("k1_re", cap_re[1], 247);    chk("k1_im", cap_im[1], -66);
    chk("k3_re", cap_re[3], 181);    chk("k3_im", cap_im[3], -181);
    chk("k6_re", cap_re[6], 0);      chk("k6_im", cap_im[6], -256);
    chk("k12_re", cap_re[12], -256); chk("k12_im", cap_im[12], 0);
    chk("k18_re", cap_re[18], 0);    chk("k18_im", cap_im[18], 256);

    // wrap check
    run_seq(5, 6, 1'b0);
    chk("wrap_len", seen_idx.size(), 6);
    for (int i = 0; i < 6 && i < seen_idx.size(); i++) chk("wrap_idx", seen_idx[i], exp5[i]);

    // inverse twiddles
    run_seq(5, 6, 1'b1);
    chk("inv_k5_im", cap_im[5], 247);

    // stride zero
    run_seq(0, 4, 1'b0);

    // count zero: done next cycle, never valid
    @(posedge clk);
    #1;
    start = 1'b1; count = 6'd0; stride = 5'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_valid", tw_valid, 0);
    @(posedge clk);
    #1;
    chk("zero_done_drop", done, 0);
    chk("zero_valid2", tw_valid, 0);
    $display("seq count=0 done pulse observed");

    // start and input changes during RUN are ignored
    start_seq(1, 20, 1'b1);
    wait_done(1, 20, 1'b1);

    // random backpressure with random parameters
    rand_mode = 1;
    for (int n = 0; n < 8; n++) begin
      s   = $urandom_range(0, 23);
      c   = $urandom_range(1, 40);
      inv = 1'($urandom_range(0, 1));
      run_seq(s, c, inv);
    end
    rand_mode = 0;
    repeat (2) @(posedge clk);

    // asynchronous reset mid-sequence
    start_seq(1, 24, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", tw_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_re", tw_re, 0);
    chk("arst_im", tw_im, 0);
    chk("arst_idx", tw_idx, 0);
    sq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("no_done_after_reset", done, 0);
      chk("idle_after_reset", busy, 0);
    end
    $display("reset mid-sequence applied");
    run_seq(7, 24, 1'b0);

    // large instance: full sweep
    @(posedge clk);
    #1;
    start_b = 1'b1; stride_b = 12'd1; count_b = 13'd4096; inverse_b = 1'b0;
    hs_cnt_b = 0;
    for (int k = 0; k < 4096; k++) begin
      e.idx = k;
      e.re  = ref_c(k, 4096, 16);
      e.im  = -ref_s(k, 4096, 16);
      bq.push_back(e);
    end
    @(posedge clk);
    #1;
    start_b = 1'b0;
    got = 0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(posedge clk);
      #1;
      if (done_b) got = 1;
    end
    chk("big_done_seen", got, 1);
    chk("big_handshakes", hs_cnt_b, 4096);
    chk("big_queue_empty", bq.size(), 0);
    $display("big sweep N=4096 handshakes=%0d", hs_cnt_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
